// File: rtl/hawk_pkg.sv
// Shared state encoding and CRC constants for the Hawk read path.
package hawk_pkg;
    localparam int          WORD_W   = 16;
    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_INIT = 16'h0000;

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, DATA, CRC} state_e;
endpackage

// File: rtl/crc16_serial.sv
// Serial CRC-16 (CRC_POLY, CRC_INIT), MSB-first, one bit per bit_valid.
// Latency: crc reflects a bit the cycle after bit_valid.
// No backpressure; clear has priority over bit_valid.
module crc16_serial
    import hawk_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC_INIT;
        end else if (bit_valid) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bit_in) ? CRC_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) crc_q <= CRC_INIT;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/hawk_read_deserializer.sv
// Hawk read deserializer: finds sync after the zero preamble, emits header/data words, checks CRC (HAWK_DESER_CRC_EN).
// Latency: pulses appear 4 clk after the rd_clock pin edge (2 sync flops, edge register, output register).
// No backpressure: every word is a single-cycle pulse; sector strobe or i_en low abandons the frame.
module hawk_read_deserializer
    import hawk_pkg::*;
#(
    parameter int DATA_WORDS   = 256,
    parameter int MIN_PREAMBLE = 16,
    parameter int MAX_PREAMBLE = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_clock,
    input  logic              i_rd_data,
    input  logic              i_sector,
    input  logic              i_en,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid,
    output logic              o_header,
    output logic              o_done,
    output logic              o_crc_err,
    output logic              o_sync_err,
    output logic              o_busy
);
    localparam int             WCW       = $clog2(DATA_WORDS + 1);
    localparam int             ZCW       = $clog2(MAX_PREAMBLE + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(DATA_WORDS - 1);
    localparam logic [ZCW-1:0] MIN_ZEROS = ZCW'(MIN_PREAMBLE);
    localparam logic [ZCW-1:0] MAX_ZEROS = ZCW'(MAX_PREAMBLE);
    localparam logic [ZCW-1:0] LAST_PRE  = ZCW'(MAX_PREAMBLE - 1);

    // [1:0] are the synchronizer stages, [2] holds the previous synchronized level
    logic [2:0]        rclk_sync_q, rclk_sync_d;
    logic [1:0]        rdat_sync_q, rdat_sync_d;
    logic [2:0]        sect_sync_q, sect_sync_d;
    logic              bit_evt_q, bit_evt_d, bit_dat_q, bit_dat_d, sect_evt_q, sect_evt_d;
    state_e            state_q, state_d;
    logic [ZCW-1:0]    zero_cnt_q, zero_cnt_d, bit_cnt_q, bit_cnt_d;
    logic [3:0]        bit_pos_q, bit_pos_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d, word_q, word_d, shift_nx;
    logic              word_valid_q, word_valid_d, header_q, header_d, done_q, done_d;
    logic              crc_err_q, crc_err_d, sync_err_q, sync_err_d;

`ifdef HAWK_DESER_CRC_EN
    logic [15:0] crc_calc;
    logic        crc_bit_vld;

    // Only header and data bits feed the CRC; the register idles cleared during PREAMBLE
    assign crc_bit_vld = bit_evt_q & ~sect_evt_q & i_en & ((state_q == HEADER) | (state_q == DATA));

    crc16_serial u_crc (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == PREAMBLE),
        .bit_valid (crc_bit_vld),
        .bit_in    (bit_dat_q),
        .crc       (crc_calc)
    );
`endif

    always_comb begin
        rclk_sync_d = {rclk_sync_q[1:0], i_rd_clock};
        rdat_sync_d = {rdat_sync_q[0], i_rd_data};
        sect_sync_d = {sect_sync_q[1:0], i_sector};
        bit_evt_d   = rclk_sync_q[1] & ~rclk_sync_q[2];
        bit_dat_d   = rdat_sync_q[1];
        sect_evt_d  = sect_sync_q[1] & ~sect_sync_q[2];
    end

    always_comb begin
        state_d      = state_q;
        zero_cnt_d   = zero_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bit_pos_d    = bit_pos_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        shift_nx     = {shift_q[WORD_W-2:0], bit_dat_q};
        word_valid_d = 1'b0;
        header_d     = 1'b0;
        done_d       = 1'b0;
        crc_err_d    = 1'b0;
        sync_err_d   = 1'b0;
        if (!i_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sect_evt_q) begin
                        state_d    = PREAMBLE;
                        zero_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                PREAMBLE: begin
                    if (sect_evt_q) begin
                        zero_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else if (bit_evt_q) begin
                        if (bit_dat_q && (zero_cnt_q >= MIN_ZEROS)) begin
                            state_d   = HEADER;
                            bit_pos_d = '0;
                        end else if (bit_cnt_q == LAST_PRE) begin
                            state_d    = IDLE;
                            sync_err_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            if (bit_dat_q)                    zero_cnt_d = '0;
                            else if (zero_cnt_q != MAX_ZEROS) zero_cnt_d = zero_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    // A sector strobe mid-frame wins over a coincident bit, which is dropped
                    if (sect_evt_q) begin
                        state_d    = PREAMBLE;
                        zero_cnt_d = '0;
                        bit_cnt_d  = '0;
                        sync_err_d = 1'b1;
                    end else if (bit_evt_q) begin
                        shift_d   = shift_nx;
                        bit_pos_d = bit_pos_q + 1'b1;
                        if (bit_pos_q == 4'hF) begin
                            if (state_q == CRC) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
`ifdef HAWK_DESER_CRC_EN
                                crc_err_d = (shift_nx != crc_calc);
`endif
                            end else begin
                                word_d       = shift_nx;
                                word_valid_d = 1'b1;
                                if (state_q == HEADER) begin
                                    header_d   = 1'b1;
                                    state_d    = DATA;
                                    word_cnt_d = '0;
                                end else if (word_cnt_q == LAST_WORD) begin
                                    state_d = CRC;
                                end else begin
                                    word_cnt_d = word_cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rclk_sync_q  <= '0;
            rdat_sync_q  <= '0;
            sect_sync_q  <= '0;
            bit_evt_q    <= 1'b0;
            bit_dat_q    <= 1'b0;
            sect_evt_q   <= 1'b0;
            state_q      <= IDLE;
            zero_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            bit_pos_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            header_q     <= 1'b0;
            done_q       <= 1'b0;
            crc_err_q    <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            rclk_sync_q  <= rclk_sync_d;
            rdat_sync_q  <= rdat_sync_d;
            sect_sync_q  <= sect_sync_d;
            bit_evt_q    <= bit_evt_d;
            bit_dat_q    <= bit_dat_d;
            sect_evt_q   <= sect_evt_d;
            state_q      <= state_d;
            zero_cnt_q   <= zero_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_pos_q    <= bit_pos_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            header_q     <= header_d;
            done_q       <= done_d;
            crc_err_q    <= crc_err_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_valid = word_valid_q;
    assign o_header     = header_q;
    assign o_done       = done_q;
    assign o_crc_err    = crc_err_q;
    assign o_sync_err   = sync_err_q;
    assign o_busy       = (state_q == HEADER) | (state_q == DATA) | (state_q == CRC);
endmodule
